// File: rtl/ctrl_pipe_pkg.sv
// Control-word layout shared by the decoder and the downstream control pipeline.
// Field indices locate individual control bits inside a decoded word.
package ctrl_pipe_pkg;

    localparam int CTRL_W = 16;
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    localparam int F_REG_WRITE  = 0;
    localparam int F_MEM_READ   = 1;
    localparam int F_MEM_WRITE  = 2;
    localparam int F_HILO_WRITE = 3;
    localparam int F_MEM_TO_REG = 4;
    localparam int F_ALU_SRC    = 5;
    localparam int F_BRANCH     = 6;
    localparam int F_JUMP       = 7;
    localparam int F_ALU_OP_LO  = 8;
    localparam int F_ALU_OP_HI  = 11;
    localparam int F_REG_DST_LO = 12;
    localparam int F_REG_DST_HI = 13;

    // Shortest multi-cycle length that actually occupies the stage for an extra cycle.
    localparam int MC_MIN_LEN = 2;

    function automatic logic ctrl_writes_state(input logic [CTRL_W-1:0] w);
        return w[F_REG_WRITE] | w[F_MEM_WRITE] | w[F_HILO_WRITE];
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline slot: control word plus valid bit, with enable and a synchronous
// clear that loads the bubble word. The clear takes priority over the enable.
module ctrl_stage_reg #(
    parameter int                 WIDTH  = 16,
    parameter logic [WIDTH-1:0]   BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] word_q;
    logic             valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q  <= BUBBLE;
            valid_q <= 1'b0;
        end else if (clr_i) begin
            word_q  <= BUBBLE;
            valid_q <= 1'b0;
        end else if (en_i) begin
            word_q  <= word_i;
            valid_q <= valid_i;
        end
    end

    assign word_o  = word_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline from decode through STAGES registers, with per-stage
// stall/flush, backward hold propagation, bubble insertion and a multi-cycle hold.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int               STAGES   = 3,
    parameter int               WIDTH    = 16,
    parameter int               MC_STAGE = 0,
    parameter int               CNTW     = 6,
    parameter logic [WIDTH-1:0] BUBBLE   = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         ctrl_in,
    input  logic                     valid_in,
    input  logic [STAGES-1:0]        stall,
    input  logic [STAGES-1:0]        flush,
    input  logic                     mc_start,
    input  logic [CNTW-1:0]          mc_len,
    output logic [STAGES*WIDTH-1:0]  ctrl_out,
    output logic [STAGES-1:0]        valid_out,
    output logic [STAGES-1:0]        hold,
    output logic                     mc_busy
);

    localparam logic [CNTW-1:0] MIN_LEN = CNTW'(MC_MIN_LEN);

    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              mc_hold;
    logic              mc_valid;
    logic [STAGES-1:0] hold_c;
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  word_q [STAGES];

    assign mc_valid = valid_q[MC_STAGE];

    // A start cycle already holds, so an op of length L is held for L-1 edges.
    always_comb begin
        mc_hold = 1'b0;
        if (mc_valid) begin
            if (cnt_q != '0) begin
                mc_hold = 1'b1;
            end else if (mc_start && (mc_len >= MIN_LEN)) begin
                mc_hold = 1'b1;
            end
        end
    end

    always_comb begin
        hold_c = '0;
        hold_c[STAGES-1] = stall[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            hold_c[i] = stall[i] | hold_c[i+1] | ((i == MC_STAGE) & mc_hold);
        end
    end

    // Counter runs regardless of external stalls; only a flush of its stage cancels it.
    always_comb begin
        cnt_d = cnt_q;
        if (flush[MC_STAGE]) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (mc_valid && mc_start && (mc_len >= MIN_LEN)) begin
            cnt_d = mc_len - MIN_LEN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic [WIDTH-1:0] d_word;
        logic             d_valid;
        logic             clr;

        if (g == 0) begin : g_head
            assign d_word  = ctrl_in;
            assign d_valid = valid_in;
            assign clr     = flush[0];
        end else begin : g_body
            assign d_word  = word_q[g-1];
            assign d_valid = valid_q[g-1];
            // Upstream held while this stage moves on: the slot fills with a bubble.
            assign clr     = flush[g] | (hold_c[g-1] & ~hold_c[g]);
        end

        ctrl_stage_reg #(
            .WIDTH  (WIDTH),
            .BUBBLE (BUBBLE)
        ) u_reg (
            .clk     (clk),
            .rst     (rst),
            .en_i    (~hold_c[g]),
            .clr_i   (clr),
            .word_i  (d_word),
            .valid_i (d_valid),
            .word_o  (word_q[g]),
            .valid_o (valid_q[g])
        );

        assign ctrl_out[g*WIDTH +: WIDTH] = word_q[g];
    end

    assign valid_out = valid_q;
    assign hold      = hold_c;
    assign mc_busy   = mc_hold;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed plus randomized bench for ctrl_pipe against a behavioural pipeline model.
module tb_ctrl_pipe;

    localparam int S  = 3;
    localparam int W  = 16;
    localparam int MC = 0;
    localparam int CW = 6;

    logic            clk;
    logic            rst;
    logic [W-1:0]    ctrl_in;
    logic            valid_in;
    logic [S-1:0]    stall;
    logic [S-1:0]    flush;
    logic            mc_start;
    logic [CW-1:0]   mc_len;
    logic [S*W-1:0]  ctrl_out;
    logic [S-1:0]    valid_out;
    logic [S-1:0]    hold;
    logic            mc_busy;

    int checks = 0;
    int errors = 0;

    // Behavioural model: words per stage, remaining held edges of the multi-cycle op.
    logic [W-1:0] m_word [S];
    logic         m_valid [S];
    int           m_rem;
    logic [S-1:0] m_hold;
    logic         m_busy;
    logic         last_busy;

    ctrl_pipe #(
        .STAGES   (S),
        .WIDTH    (W),
        .MC_STAGE (MC),
        .CNTW     (CW),
        .BUBBLE   ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl_in   (ctrl_in),
        .valid_in  (valid_in),
        .stall     (stall),
        .flush     (flush),
        .mc_start  (mc_start),
        .mc_len    (mc_len),
        .ctrl_out  (ctrl_out),
        .valid_out (valid_out),
        .hold      (hold),
        .mc_busy   (mc_busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed no_finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            m_word[i]  = '0;
            m_valid[i] = 1'b0;
        end
        m_rem = 0;
    endtask

    task automatic model_comb();
        m_busy = m_valid[MC] && ((m_rem > 0) || (mc_start && (int'(mc_len) >= 2)));
        m_hold = '0;
        m_hold[S-1] = stall[S-1];
        for (int i = S - 2; i >= 0; i--) begin
            m_hold[i] = stall[i] | m_hold[i+1] | ((i == MC) && m_busy);
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] nw [S];
        logic         nv [S];
        for (int i = 0; i < S; i++) begin
            if (flush[i]) begin
                nw[i] = '0; nv[i] = 1'b0;
            end else if (m_hold[i]) begin
                nw[i] = m_word[i]; nv[i] = m_valid[i];
            end else if (i > 0 && m_hold[i-1]) begin
                nw[i] = '0; nv[i] = 1'b0;
            end else if (i == 0) begin
                nw[i] = ctrl_in; nv[i] = valid_in;
            end else begin
                nw[i] = m_word[i-1]; nv[i] = m_valid[i-1];
            end
        end
        if (flush[MC])
            m_rem = 0;
        else if (m_rem > 0)
            m_rem = m_rem - 1;
        else if (m_valid[MC] && mc_start && int'(mc_len) >= 2)
            m_rem = int'(mc_len) - 2;
        for (int i = 0; i < S; i++) begin
            m_word[i]  = nw[i];
            m_valid[i] = nv[i];
        end
    endtask

    function automatic logic [S*W-1:0] pack_words();
        logic [S*W-1:0] r;
        for (int i = 0; i < S; i++) r[i*W +: W] = m_word[i];
        return r;
    endfunction

    function automatic logic [S-1:0] pack_valid();
        logic [S-1:0] r;
        for (int i = 0; i < S; i++) r[i] = m_valid[i];
        return r;
    endfunction

    // Driver tasks
    task automatic drive(input logic [W-1:0] w, input logic v, input logic [S-1:0] st,
                         input logic [S-1:0] fl, input logic ms, input logic [CW-1:0] ml);
        ctrl_in  = w;
        valid_in = v;
        stall    = st;
        flush    = fl;
        mc_start = ms;
        mc_len   = ml;
    endtask

    task automatic step();
        #1;
        model_comb();
        last_busy = mc_busy;
        chk("hold", 64'(hold), 64'(m_hold));
        chk("mc_busy", 64'(mc_busy), 64'(m_busy));
        @(posedge clk);
        model_edge();
        #1;
        chk("ctrl_out", 64'(ctrl_out), 64'(pack_words()));
        chk("valid_out", 64'(valid_out), 64'(pack_valid()));
    endtask

    initial begin
        int busy_cnt;
        logic [W-1:0] mc_word;

        drive('0, 1'b0, '0, '0, 1'b0, '0);
        rst = 1'b0;
        model_reset();
        #12;
        chk("reset_ctrl_out", 64'(ctrl_out), 64'h0);
        chk("reset_valid_out", 64'(valid_out), 64'h0);
        chk("reset_hold", 64'(hold), 64'h0);
        chk("reset_mc_busy", 64'(mc_busy), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Stream 1,2,3: word 1 reaches the last stage on the third edge.
        drive(16'h0001, 1'b1, '0, '0, 1'b0, '0); step();
        drive(16'h0002, 1'b1, '0, '0, 1'b0, '0); step();
        drive(16'h0003, 1'b1, '0, '0, 1'b0, '0); step();
        chk("latency_stage2", 64'(ctrl_out[2*W +: W]), 64'h0001);
        chk("latency_valid", 64'(valid_out), 64'b111);

        // One-cycle stall of stage 1 with the pipe full.
        drive(16'h0004, 1'b1, 3'b010, '0, 1'b0, '0);
        #1;
        chk("stall1_hold", 64'(hold), 64'b011);
        step();
        chk("stall1_s0", 64'(ctrl_out[0 +: W]), 64'h0003);
        chk("stall1_s1", 64'(ctrl_out[W +: W]), 64'h0002);
        chk("stall1_valid", 64'(valid_out), 64'b011);

        // Flush stage 0 while stage 1 stalls.
        drive(16'h0005, 1'b1, 3'b010, 3'b001, 1'b0, '0);
        #1;
        chk("flush_stall_hold0", 64'(hold[0]), 64'h1);
        step();
        chk("flush_stall_s0", 64'(ctrl_out[0 +: W]), 64'h0);
        chk("flush_stall_s1", 64'(ctrl_out[W +: W]), 64'h0002);

        // Refill, then a 5-cycle multi-cycle op in stage 0.
        for (int i = 0; i < 3; i++) begin
            drive(W'(16'h0010 + i), 1'b1, '0, '0, 1'b0, '0); step();
        end
        mc_word = ctrl_out[0 +: W];
        busy_cnt = 0;
        drive(16'h0020, 1'b1, '0, '0, 1'b1, 6'd5); step();
        busy_cnt += int'(last_busy);
        for (int i = 0; i < 4; i++) begin
            drive(W'(16'h0021 + i), 1'b1, '0, '0, 1'b0, 6'd5); step();
            busy_cnt += int'(last_busy);
        end
        chk("mc5_busy_cycles", 64'(busy_cnt), 64'd4);
        chk("mc5_advanced", 64'(ctrl_out[W +: W]), 64'(mc_word));

        // mc_len of 1 never holds.
        drive(16'h0030, 1'b1, '0, '0, 1'b1, 6'd1); step();
        chk("mc1_busy", 64'(last_busy), 64'h0);
        drive(16'h0031, 1'b1, '0, '0, 1'b0, 6'd1); step();
        chk("mc1_after", 64'(last_busy), 64'h0);

        // mc_start ignored while stage 0 holds no valid word.
        drive(16'h0032, 1'b0, '0, '0, 1'b0, '0); step();
        drive(16'h0033, 1'b1, '0, '0, 1'b1, 6'd5); step();
        chk("mc_invalid_busy", 64'(last_busy), 64'h0);
        drive(16'h0034, 1'b1, '0, '0, 1'b0, '0); step();
        chk("mc_invalid_after", 64'(last_busy), 64'h0);

        // Reset in the middle of an active op (counter at 3).
        drive(16'h0040, 1'b1, '0, '0, 1'b1, 6'd5); step();
        drive(16'h0041, 1'b1, '0, '0, 1'b0, '0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("midrst_ctrl_out", 64'(ctrl_out), 64'h0);
        chk("midrst_valid_out", 64'(valid_out), 64'h0);
        chk("midrst_mc_busy", 64'(mc_busy), 64'h0);
        chk("midrst_hold", 64'(hold), 64'h0);
        #2;
        rst = 1'b1;
        drive(16'h0050, 1'b1, '0, '0, 1'b0, '0); step();
        chk("restart_s0", 64'(ctrl_out[0 +: W]), 64'h0050);
        chk("restart_valid", 64'(valid_out), 64'b001);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [S-1:0] st;
            logic [S-1:0] fl;
            for (int i = 0; i < S; i++) begin
                st[i] = ($urandom_range(0, 7) == 0);
                fl[i] = ($urandom_range(0, 15) == 0);
            end
            drive(W'($urandom), ($urandom_range(0, 3) != 0), st, fl,
                  ($urandom_range(0, 5) == 0), CW'($urandom_range(0, 7)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised control-word pipeline that carries decoded control fields from decode through STAGES downstream pipeline registers (EX/MEM/WB and beyond). It generalises the fixed per-stage control flops: every stage has its own valid bit, stall and flush. Stalls propagate backwards with automatic bubble insertion. One configurable stage may be held for a multi-cycle operation (e.g. HI/LO divide) by an internal occupancy counter.

## Interface
- STAGES, default 3: number of pipeline registers after decode (≥2).
- WIDTH, default 16: control-word width in bits.
- MC_STAGE, default 0: index of the stage that may be held by a multi-cycle op (0 = EX).
- CNTW, default 6: width of the multi-cycle length field.
- BUBBLE, default all-zero: control word loaded on flush/bubble/reset.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ctrl_in  in  WIDTH  decoded control word from decode
- valid_in  in  1  ctrl_in is a real instruction
- stall  in  STAGES  external hold request per stage
- flush  in  STAGES  synchronous clear per stage
- mc_start  in  1  word in stage MC_STAGE begins a multi-cycle op
- mc_len  in  CNTW  total occupancy cycles of that op
- ctrl_out  out  STAGES*WIDTH  stage i word at bits [i*WIDTH +: WIDTH]
- valid_out  out  STAGES  stage i valid
- hold  out  STAGES  effective hold per stage; hold[0] also stalls fetch/decode
- mc_busy  out  1  multi-cycle hold active this cycle

## Operation
- Reset (rst low, asynchronous): every ctrl_out stage = BUBBLE, valid_out = 0, counter = 0. Hold and mc_busy then read 0 unless stall is asserted.
- mc_hold = valid_out[MC_STAGE] & ((cnt != 0) | (cnt == 0 & mc_start & mc_len ≥ 2)).
- Effective hold, computed from the last stage backwards: hold[STAGES-1] = stall[STAGES-1]. hold[i] = stall[i] | hold[i+1] | (i == MC_STAGE & mc_hold).
- Per-stage update at each clock edge, in priority order:
  1. flush[i]: load BUBBLE, valid 0.
  2. hold[i]: keep the current word.
  3. i > 0 and hold[i-1]: load BUBBLE, valid 0 (bubble insertion).
  4. Otherwise load the upstream word. Stage 0 loads ctrl_in/valid_in; stage i loads stage i-1.
- Flush beats hold. A flushed held stage becomes a bubble, and upstream stays held only if hold[i-1] is still true.
- The counter is a CNTW-bit down-counter:
  - Idle at 0. While idle, mc_start is sampled only when valid_out[MC_STAGE] = 1.
  - On start with mc_len = L ≥ 2: cnt ← L−2.
  - While cnt ≠ 0: decrement by 1 per edge. mc_start is ignored.
  - mc_len of 0 or 1 never holds.
  - flush[MC_STAGE] forces cnt ← 0.
  - External stall does not pause the counter.
- mc_busy = mc_hold.

## Timing
- Latency: ctrl_in appears at stage 0 one edge after capture. It appears at stage i after i+1 edges with no holds.
- hold, mc_busy: combinational from stall, flush-independent inputs and registered state. There is no combinational path from ctrl_in.
- Multi-cycle op of length L occupies MC_STAGE for exactly L cycles: held for L−1 edges, advancing on the Lth edge.
- Simultaneous stall[j] and flush[k], k < j: stage k bubbles while stages ≤ j hold. Flush wins at k.
- Reset asserted mid-operation clears all state immediately, including an active counter. Deassertion is synchronised externally.

## Structure
- Package ctrl_pipe_pkg: bubble-word constant and field-index localparams for the control word (RegWrite, MemRead, MemWrite, HiloWrite, ...) shared with the decoder.
- Sub-module ctrl_stage_reg: WIDTH+1-bit register with async active-low reset to BUBBLE/0, enable and synchronous clear. It is instantiated STAGES times by generate.
- The counter and hold chain live in the top level.

## Test plan
- Reset, then stream words 0x0001, 0x0002, 0x0003 with valid_in=1 and STAGES=3 → 0x0001 appears at stage 2 on the third edge; all valid_out = 1 by edge 3.
- stall[1] for one cycle with the pipe full → stages 0 and 1 keep their words, stage 2 gets BUBBLE with valid 0, hold = 3'b011.
- flush[0] and stall[1] together → stage 0 becomes BUBBLE, stage 1 holds, hold[0] = 1.
- mc_start with mc_len=5 at MC_STAGE=0 → mc_busy high for 4 cycles, stage 0 word advances on the 5th edge, stage 1 receives 4 bubbles.
- mc_len=1, and separately mc_start with valid_out[0]=0 → no hold, counter stays 0.
- rst low during an active mc op with cnt=3 → all outputs BUBBLE/0, mc_busy 0 immediately; after release the pipe restarts cleanly.
